// File: rtl/inv_sub_bytes_pkg.sv
// Shared types, sizes and helpers for the iterative AES inverse-SubBytes engine.
package inv_sub_bytes_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} isb_state_t;

  localparam int BLOCK_BITS = 128;
  localparam int BYTES      = 16;

  // Byte index handled by a given lane during a given pass; the modulo keeps
  // the index in range for unreachable counter values.
  function automatic int byte_sel(input int pass, input int lane, input int num_sbox);
    return (pass * num_sbox + lane) % BYTES;
  endfunction

endpackage

// File: rtl/InvSBox.sv
// AES inverse S-box: purely combinational 8-bit lookup, message -> crypte.
module InvSBox (
  input  logic [7:0] message,
  output logic [7:0] crypte
);

  // Entry k occupies bits [8k:8k+7]; row r of the literal holds inputs 16r..16r+15.
  localparam logic [0:2047] INV_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign crypte = INV_TABLE[{message, 3'b000} +: 8];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Iterative inverse-SubBytes engine: NUM_SBOX InvSBox lookups per cycle over
// the 16 bytes of a state held in place, with valid/ready on both sides.
module inv_sub_bytes_seq
  import inv_sub_bytes_pkg::*;
#(
  parameter int NUM_SBOX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  abort,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [0:BLOCK_BITS-1] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [0:BLOCK_BITS-1] out_data,
  output logic                  busy
);

  localparam int PASSES = BYTES / NUM_SBOX;
  localparam int CNT_W  = (PASSES > 1) ? $clog2(PASSES) : 1;

  if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 ||
        NUM_SBOX == 8 || NUM_SBOX == 16)) begin : g_bad_num_sbox
    $error("inv_sub_bytes_seq: NUM_SBOX must be 1, 2, 4, 8 or 16");
  end

  isb_state_t            fsm_q, fsm_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [0:BLOCK_BITS-1] state_q, state_d;
  logic [7:0]            lane_in  [NUM_SBOX];
  logic [7:0]            lane_out [NUM_SBOX];
  logic                  accept;

  // Byte-lane mux: each lookup unit sees the byte it owns in the current pass.
  always_comb begin
    for (int l = 0; l < NUM_SBOX; l++) begin
      lane_in[l] = state_q[8*byte_sel(int'(cnt_q), l, NUM_SBOX) +: 8];
    end
  end

  for (genvar g = 0; g < NUM_SBOX; g++) begin : g_sbox
    InvSBox u_inv_sbox (
      .message (lane_in[g]),
      .crypte  (lane_out[g])
    );
  end

  assign in_ready  = !rst && !abort &&
                     ((fsm_q == IDLE) || ((fsm_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q != IDLE);
  assign out_data  = state_q;

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    unique case (fsm_q)
      IDLE: begin
        if (accept) begin
          fsm_d   = RUN;
          cnt_d   = '0;
          state_d = in_data;
        end
      end
      RUN: begin
        for (int l = 0; l < NUM_SBOX; l++) begin
          state_d[8*byte_sel(int'(cnt_q), l, NUM_SBOX) +: 8] = lane_out[l];
        end
        if (cnt_q == CNT_W'(PASSES - 1)) begin
          cnt_d = '0;
          fsm_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        // A waiting input block is taken on the same edge the result leaves.
        if (accept) begin
          fsm_d   = RUN;
          cnt_d   = '0;
          state_d = in_data;
        end else if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
    if (abort) begin
      fsm_d   = IDLE;
      cnt_d   = '0;
      state_d = state_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      cnt_q   <= '0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Self-checking bench for inv_sub_bytes_seq; the reference inverse S-box is
// derived from GF(2^8) arithmetic rather than a lookup table.
module tb_inv_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst, abort, in_valid, out_ready;
  logic [0:127] in_data;
  logic         in_ready, out_valid, busy;
  logic [0:127] out_data;

  logic         v_in_valid, v_out_ready, v_abort;
  logic         v_in_ready  [4];
  logic         v_out_valid [4];
  logic         v_busy      [4];
  logic [0:127] v_out_data  [4];

  int   n_assert = 0;
  int   n_fail   = 0;
  logic [7:0] inv_tab [256];

  always #5 clk = ~clk;

  inv_sub_bytes_seq #(.NUM_SBOX(4)) dut (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  // Variants with NUM_SBOX = 1, 2, 8, 16.
  for (genvar g = 0; g < 4; g++) begin : g_var
    inv_sub_bytes_seq #(.NUM_SBOX((g < 2) ? (1 << g) : (1 << (g + 1)))) u_var (
      .clk(clk), .rst(rst), .abort(v_abort), .in_valid(v_in_valid),
      .in_ready(v_in_ready[g]), .in_data(in_data), .out_valid(v_out_valid[g]),
      .out_ready(v_out_ready), .out_data(v_out_data[g]), .busy(v_busy[g])
    );
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      hi = a[7];
      a  = a << 1;
      if (hi) a ^= 8'h1b;
      b  = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Forward S-box = affine(GF inverse); the reference is its inversion.
  task automatic buildModel();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [0:127] refIsb(input logic [0:127] d);
    logic [0:127] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [0:127] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send one block with out_ready high; checks latency and result.
  task automatic applyStimulus(input logic [0:127] d, input logic [0:127] exp,
                               input int latExp, input string tag);
    int lat;
    in_data   = d;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    checkOutput({tag, "_ready"}, 128'(in_ready), 128'(1));
    step();
    in_valid = 1'b0;
    in_data  = rand128();
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    checkOutput({tag, "_latency"}, 128'(lat), 128'(latExp));
    checkOutput({tag, "_data"}, out_data, exp);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [0:127] d, exp, kat_in, kat_out, hold;
    int lat [4];
    int first, second, t, cnt;
    logic prev;

    buildModel();
    kat_in  = 128'h000102030405060708090a0b0c0d0e0f;
    kat_out = 128'h52096ad53036a538bf40a39e81f3d7fb;

    rst = 1'b1; abort = 1'b0; in_valid = 1'b1; out_ready = 1'b0; in_data = '0;
    v_in_valid = 1'b0; v_out_ready = 1'b1; v_abort = 1'b0;

    $display("[TB] reset");
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("rst_in_ready", 128'(in_ready), 128'(0));
      checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
      checkOutput("rst_busy", 128'(busy), 128'(0));
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", 128'(in_ready), 128'(1));

    $display("[TB] known answer");
    checkOutput("kat_model", refIsb(kat_in), kat_out);
    applyStimulus(kat_in, kat_out, 4, "kat4");

    in_data = kat_in; v_in_valid = 1'b1;
    step();
    v_in_valid = 1'b0;
    for (int v = 0; v < 4; v++) lat[v] = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      for (int v = 0; v < 4; v++) begin
        if (v_out_valid[v] && lat[v] == 0) begin
          lat[v] = c;
          checkOutput($sformatf("kat_var%0d_data", v), v_out_data[v], kat_out);
        end
      end
    end
    checkOutput("kat_ns1_latency", 128'(lat[0]), 128'(16));
    checkOutput("kat_ns2_latency", 128'(lat[1]), 128'(8));
    checkOutput("kat_ns8_latency", 128'(lat[2]), 128'(2));
    checkOutput("kat_ns16_latency", 128'(lat[3]), 128'(1));

    $display("[TB] uniform bytes");
    applyStimulus({16{8'h63}}, {16{8'h00}}, 4, "u63");
    applyStimulus({16{8'h16}}, {16{8'hff}}, 4, "u16");
    applyStimulus({16{8'hed}}, {16{8'h53}}, 4, "ued");

    $display("[TB] random blocks");
    for (int i = 0; i < 8; i++) begin
      d = rand128();
      applyStimulus(d, refIsb(d), 4, $sformatf("rnd%0d", i));
    end

    $display("[TB] backpressure and fall-through");
    d = rand128();
    exp = refIsb(d);
    in_data = d; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0; in_data = rand128();
    repeat (4) step();
    checkOutput("bp_valid", 128'(out_valid), 128'(1));
    hold = out_data;
    checkOutput("bp_data", hold, exp);
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("bp_hold", out_data, exp);
      checkOutput("bp_in_ready", 128'(in_ready), 128'(0));
    end
    in_valid = 1'b1; in_data = {16{8'h7c}}; out_ready = 1'b1;
    #1;
    checkOutput("ft_ready", 128'(in_ready), 128'(1));
    step();
    checkOutput("ft_accept_valid", 128'(out_valid), 128'(0));
    checkOutput("ft_accept_busy", 128'(busy), 128'(1));
    first = -1; second = -1; prev = 1'b0;
    for (t = 1; t <= 12; t++) begin
      step();
      if (out_valid && !prev) begin
        if (first < 0) first = t;
        else if (second < 0) second = t;
        checkOutput("ft_data", out_data, {16{8'h01}});
      end
      prev = out_valid;
    end
    checkOutput("ft_latency", 128'(first), 128'(4));
    checkOutput("ft_period", 128'(second - first), 128'(5));
    in_valid = 1'b0;
    cnt = 0;
    while (busy && cnt < 20) begin
      step();
      cnt++;
    end
    checkOutput("ft_drain", 128'(busy), 128'(0));

    $display("[TB] abort");
    in_data = rand128(); in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    abort = 1'b1;
    #1;
    checkOutput("abort_run_in_ready", 128'(in_ready), 128'(0));
    step();
    abort = 1'b0;
    checkOutput("abort_run_busy", 128'(busy), 128'(0));
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) cnt++;
    end
    checkOutput("abort_run_no_valid", 128'(cnt), 128'(0));

    in_data = rand128(); in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    checkOutput("abort_done_valid", 128'(out_valid), 128'(1));
    abort = 1'b1;
    #1;
    checkOutput("abort_done_in_ready", 128'(in_ready), 128'(0));
    step();
    abort = 1'b0;
    checkOutput("abort_done_dropped", 128'(out_valid), 128'(0));
    checkOutput("abort_done_busy", 128'(busy), 128'(0));

    abort = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checkOutput("abort_idle_in_ready", 128'(in_ready), 128'(0));
    step();
    checkOutput("abort_idle_no_accept", 128'(busy), 128'(0));
    abort = 1'b0; in_valid = 1'b0;

    $display("[TB] reset mid-run");
    in_data = rand128(); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    checkOutput("midrun_busy", 128'(busy), 128'(1));
    rst = 1'b1;
    step();
    checkOutput("midrun_rst_busy", 128'(busy), 128'(0));
    checkOutput("midrun_rst_valid", 128'(out_valid), 128'(0));
    rst = 1'b1; abort = 1'b1; in_valid = 1'b1;
    #1;
    checkOutput("rst_abort_in_ready", 128'(in_ready), 128'(0));
    step();
    checkOutput("rst_abort_busy", 128'(busy), 128'(0));
    checkOutput("rst_abort_valid", 128'(out_valid), 128'(0));
    rst = 1'b0; abort = 1'b0; in_valid = 1'b0;
    step();
    d = rand128();
    applyStimulus(d, refIsb(d), 4, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/inv_sub_bytes_seq.md
Name: inv_sub_bytes_seq

Overview:
Iterative inverse-SubBytes engine for the AES-128 decryption datapath. It time-multiplexes NUM_SBOX InvSBox lookups over the 16 bytes of a 128-bit state, using valid/ready handshakes on both sides. It sits between the InvShiftRows and AddRoundKey stages of the decryption round and trades area against latency.

Parameters:
NUM_SBOX, 4, number of InvSBox instances used in parallel; legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
PASSES, 16/NUM_SBOX, derived localparam (not overridable); number of substitution passes per block.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
abort  input  1  synchronous flush; drops the block in flight.
in_valid  input  1  in_data is valid.
in_ready  output  1  block can accept in_data.
in_data  input  [0:127]  ciphertext state; byte i = bits [8i:8i+7], byte 0 = bits [0:7].
out_valid  output  1  out_data holds a completed result.
out_ready  input  1  downstream accepts out_data.
out_data  output  [0:127]  InvSubBytes(in_data), same byte order.
busy  output  1  high in RUN or DONE.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- FSM states: IDLE, RUN, DONE. Internal registers: state_q[0:127], pass counter cnt with width max(1, $clog2(PASSES)).
- Reset (rst high at a rising edge):
  - FSM goes to IDLE; cnt = 0; state_q = 0; out_valid = 0; busy = 0.
  - in_ready is forced to 0 while rst is high.
  - Reset overrides every other input in any state, including mid-RUN.
- in_ready is combinational: !rst && !abort && (IDLE || (DONE && out_ready)).
- Accept:
  - An accept occurs on a rising edge where in_valid && in_ready.
  - On accept: state_q <= in_data; cnt <= 0; FSM -> RUN.
  - in_data is sampled only at accept; it may change freely otherwise.
- RUN:
  - On each edge, bytes cnt*NUM_SBOX .. cnt*NUM_SBOX+NUM_SBOX-1 of state_q are replaced in place by their InvSBox values. All other bytes hold.
  - cnt increments on each pass.
  - On the edge that completes pass PASSES-1: cnt <= 0 and FSM -> DONE.
  - NUM_SBOX=16 means one pass: RUN lasts exactly one cycle.
- Latency: out_valid rises exactly PASSES edges after the accepting edge (4 with the default).
- DONE:
  - out_valid = 1; out_data = state_q, held stable until accepted.
  - On an edge with out_ready: if in_valid is also high, the next block is accepted on the same edge (FSM -> RUN, new state_q). Otherwise FSM -> IDLE.
  - Sustained throughput is one block per PASSES+1 cycles.
- out_valid = (FSM == DONE), registered; out_data = state_q at all times. out_data is don't-care when out_valid is low; verification checks it only when out_valid is high.
- busy = (FSM != IDLE).
- abort:
  - On an edge with abort high and rst low: FSM -> IDLE, cnt <= 0, state_q holds.
  - In DONE, the pending result is dropped with no handshake.
  - abort in IDLE is a no-op. abort together with in_valid never accepts, because in_ready = 0.
- in_valid during RUN is ignored; in_ready = 0.
- Substitution datapath: combinational from state_q; no multi-cycle paths.

Decomposition:
- Package inv_sub_bytes_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} isb_state_t;
  - localparam BLOCK_BITS = 128 and BYTES = 16;
  - function byte_sel(pass, lane) returning the byte index pass*NUM_SBOX+lane.
- Sub-modules: NUM_SBOX instances of the existing InvSBox (message -> crypte), created in a generate loop. No new sub-module; a byte-lane mux feeds each instance from state_q.

Test Plan:
1. Reset: hold rst 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, busy=0 throughout; after release, in_ready=1.
2. Known answer: in_data = 0x000102030405060708090A0B0C0D0E0F, out_ready=1 -> out_valid rises 4 edges after accept, out_data = 0x52096AD53036A538BF40A39E81F3D7FB; repeat with NUM_SBOX=1, 2, 8, 16 -> latency 16, 8, 2, 1 and the same data.
3. Uniform bytes: all 0x63 -> all 0x00; all 0x16 -> all 0xFF; all 0xED -> all 0x53.
4. Backpressure and fall-through: out_ready=0 for 10 cycles -> out_data stable and in_ready=0; then out_ready=1 with in_valid=1 (all 0x7C) -> accept on the same edge, next result all 0x01, back-to-back period 5 cycles.
5. Abort: assert abort in cycle 2 of RUN -> busy=0 next cycle, no out_valid ever; repeat in DONE -> out_valid drops without out_ready. Assert abort+in_valid in IDLE -> no accept.
6. Reset mid-RUN, and rst+abort+in_valid together -> IDLE, out_valid=0; a following clean block still produces a correct result.
